// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock divider clk_div_n:
//   DIV_MIN     - smallest divisor the counter can realise (one high, one low)
//   ST_*        - FSM state encodings (IDLE / RUN / STOP)
//   div_clamp() - forces a requested divisor of 0 or 1 up to DIV_MIN
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam logic [31:0] DIV_MIN = 32'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    // Divisors below DIV_MIN cannot produce both a high and a low phase,
    // so they are raised to DIV_MIN before they ever reach the counter.
    function automatic logic [31:0] div_clamp(input logic [31:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/clk_div_n_if.sv
// -----------------------------------------------------------------------------
// clk_div_n_if
// Control/status bundle of the clock divider.
//   en       - run request (level)
//   div_val  - new divisor, captured when div_load pulses
//   div_load - one-cycle load strobe
//   clk_out  - divided clock
//   tick     - one-cycle strobe on the clk edge where clk_out rises
//   cur_div  - divisor currently in effect
//   pend     - a loaded divisor is waiting for the next period boundary
// Modports: master = user of the divider, slave = the divider itself.
// -----------------------------------------------------------------------------
interface clk_div_n_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] cur_div;
    logic             pend;

    modport master (
        output en, div_val, div_load,
        input  clk_out, tick, cur_div, pend
    );

    modport slave (
        input  en, div_val, div_load,
        output clk_out, tick, cur_div, pend
    );
endinterface

// File: rtl/clk_div_odd_ext.sv
// -----------------------------------------------------------------------------
// clk_div_odd_ext
// Half-cycle stretcher for odd divisors. A negedge flop delays the posedge
// clk_out register by half a clk period; OR-ing both widens the high phase
// from H to H+0.5 cycles, which is exactly 50% duty for odd N. For even N the
// posedge register passes straight through.
// Ports:
//   clk, rst_n - source clock, asynchronous active-low reset
//   odd        - current divisor is odd
//   pos_q      - posedge-registered divided clock
//   clk_out    - duty-corrected divided clock
// The module only exists when CLK_DIV_ODD50_EN is defined, so the default
// build carries no negedge logic at all.
// -----------------------------------------------------------------------------
`ifdef CLK_DIV_ODD50_EN
module clk_div_odd_ext (
    input  logic clk,
    input  logic rst_n,
    input  logic odd,
    input  logic pos_q,
    output logic clk_out
);

    logic neg_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // Both terms are flop outputs, so the OR cannot glitch; reset clears both
    // asynchronously, dropping the output immediately.
    assign clk_out = pos_q | (odd & neg_q);

endmodule
`endif

// File: rtl/clk_div_n.sv
// -----------------------------------------------------------------------------
// clk_div_n
// Runtime-programmable integer clock divider: clk / N for N in 2..2^CNT_W-1.
// A shadow register holds newly loaded divisors until the current output
// period ends, so the waveform never shows a runt pulse. Dropping en lets the
// running period finish before the output parks low.
//
// Parameters:
//   CNT_W   - width of the divisor and the period counter
//   DEF_DIV - divisor in effect after reset (2..2^CNT_W-1)
// Ports:
//   clk   - source clock
//   rst_n - asynchronous active-low reset
//   bus   - clk_div_n_if.slave: en, div_val, div_load in;
//           clk_out, tick, cur_div, pend out
// Configuration:
//   CLK_DIV_ODD50_EN - when defined, odd divisors get exactly 50% duty via a
//                      negedge stretcher (clk_div_odd_ext); otherwise odd N is
//                      high for H cycles and low for H+1 (H = N>>1).
// -----------------------------------------------------------------------------
module clk_div_n #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    clk_div_n_if.slave bus
);

    import clk_div_pkg::*;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cur_div;
    logic [CNT_W-1:0] shadow;
    logic             pend;
    logic             clk_out_r;
    logic             tick_r;
    logic             clk_out_w;

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] load_val;
    logic             wrap;
    logic             apply;

    assign half    = cur_div >> 1;
    assign cnt_inc = cnt + CNT_W'(1);

    // The last count of a period; only meaningful while the counter runs.
    assign wrap = (state != ST_IDLE) && (cnt == cur_div - CNT_W'(1));

    // A pending divisor lands on a period boundary, or straight away when the
    // divider is idle (no waveform to disturb). A load on that same edge
    // refills the shadow and waits for the following boundary.
    assign apply = pend && ((state == ST_IDLE) || wrap);

    assign load_val = CNT_W'(div_clamp(32'(bus.div_val)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cur_div   <= CNT_W'(DEF_DIV);
            shadow    <= CNT_W'(DEF_DIV);
            pend      <= 1'b0;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            if (apply) begin
                cur_div <= shadow;
            end
            if (bus.div_load) begin
                shadow <= load_val;
            end
            pend   <= bus.div_load | (pend & ~apply);
            tick_r <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (bus.en) begin
                        // Start a period immediately: first rise one edge after en.
                        state     <= ST_RUN;
                        clk_out_r <= 1'b1;
                        tick_r    <= 1'b1;
                    end else begin
                        clk_out_r <= 1'b0;
                    end
                end

                ST_RUN, ST_STOP: begin
                    if ((state == ST_STOP) && !bus.en && wrap) begin
                        // Stopping period has finished: park low.
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        clk_out_r <= 1'b0;
                    end else begin
                        // en re-asserted during STOP simply resumes RUN; the
                        // counter is never touched, so the waveform is seamless.
                        state <= bus.en ? ST_RUN : ST_STOP;
                        if (wrap) begin
                            cnt       <= '0;
                            clk_out_r <= 1'b1;
                            tick_r    <= 1'b1;
                        end else begin
                            cnt       <= cnt_inc;
                            clk_out_r <= (cnt_inc < half);
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    clk_out_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_DIV_ODD50_EN
    clk_div_odd_ext u_odd_ext (
        .clk     (clk),
        .rst_n   (rst_n),
        .odd     (cur_div[0]),
        .pos_q   (clk_out_r),
        .clk_out (clk_out_w)
    );
`else
    assign clk_out_w = clk_out_r;
`endif

    assign bus.clk_out = clk_out_w;
    assign bus.tick    = tick_r;
    assign bus.cur_div = cur_div;
    assign bus.pend    = pend;

endmodule

// File: tb/tb_clk_div_n.sv
// -----------------------------------------------------------------------------
// tb_clk_div_n
// Directed bench for clk_div_n (CNT_W=8, DEF_DIV=2). Outputs are sampled 1 ns
// after each rising clk edge; inputs change at that same point.
// Wave patterns are given LSB-first: bit i is the value after the i-th edge.
// -----------------------------------------------------------------------------
module tb_clk_div_n;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    clk_div_n_if #(.CNT_W(8)) bus ();

    clk_div_n #(
        .CNT_W   (8),
        .DEF_DIV (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CLK_DIV_ODD50_EN
    // Odd divisors: the half-cycle stretch is visible at the first sample of
    // what would otherwise be the low phase.
    localparam logic [31:0] N5_CLK  = 32'b100111;
    localparam logic [31:0] N57_CLK = 32'b1000111100;
`else
    localparam logic [31:0] N5_CLK  = 32'b100011;
    localparam logic [31:0] N57_CLK = 32'b1000011100;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_wave(input string tag, input int n,
                               input logic [31:0] cpat, input logic [31:0] tpat);
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("%s clk_out[%0d]", tag, i), {31'd0, bus.clk_out}, {31'd0, cpat[i]});
            check($sformatf("%s tick[%0d]", tag, i), {31'd0, bus.tick}, {31'd0, tpat[i]});
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.div_val  = 8'd0;
        bus.div_load = 1'b0;

        // Reset state
        step();
        step();
        check("rst clk_out", {31'd0, bus.clk_out}, 32'd0);
        check("rst tick", {31'd0, bus.tick}, 32'd0);
        check("rst pend", {31'd0, bus.pend}, 32'd0);
        check("rst cur_div", 32'(bus.cur_div), 32'd2);
        rst_n = 1'b1;
        step();
        check("idle clk_out", {31'd0, bus.clk_out}, 32'd0);

        // N=2: first rise one edge after en, then toggling, tick every 2nd edge
        bus.en = 1'b1;
        expect_wave("n2", 6, 32'b010101, 32'b010101);

        // Load 4 on the wrap edge itself: takes effect at the following wrap
        bus.div_val  = 8'd4;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        check("wrapload pend", {31'd0, bus.pend}, 32'd1);
        check("wrapload cur_div", 32'(bus.cur_div), 32'd2);
        step();
        step();
        check("n4 cur_div", 32'(bus.cur_div), 32'd4);
        check("n4 pend", {31'd0, bus.pend}, 32'd0);
        check("n4 tick", {31'd0, bus.tick}, 32'd1);

        // Load 5 mid-period of N=4: pending until the 4-cycle period ends
        step();
        bus.div_val  = 8'd5;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        check("n5 pend a", {31'd0, bus.pend}, 32'd1);
        check("n5 cur_div a", 32'(bus.cur_div), 32'd4);
        check("n5 clk_out a", {31'd0, bus.clk_out}, 32'd0);
        step();
        check("n5 pend b", {31'd0, bus.pend}, 32'd1);
        expect_wave("n5", 6, N5_CLK, 32'b100001);
        check("n5 cur_div", 32'(bus.cur_div), 32'd5);
        check("n5 pend", {31'd0, bus.pend}, 32'd0);

        // Two loads (3 then 7) in one period: only 7 is applied
        bus.div_val  = 8'd3;
        bus.div_load = 1'b1;
        step();
        bus.div_val  = 8'd7;
        step();
        bus.div_load = 1'b0;
        check("n7 pend", {31'd0, bus.pend}, 32'd1);
        check("n7 cur_div a", 32'(bus.cur_div), 32'd5);
        expect_wave("n7", 10, N57_CLK, 32'b1000000100);
        check("n7 cur_div", 32'(bus.cur_div), 32'd7);
        check("n7 pend clr", {31'd0, bus.pend}, 32'd0);

        // Switch to N=6, then drop en at cnt=1: period finishes, output parks
        bus.div_val  = 8'd6;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("n6 cur_div", 32'(bus.cur_div), 32'd6);
        check("n6 tick", {31'd0, bus.tick}, 32'd1);
        step();
        bus.en = 1'b0;
        expect_wave("stop", 6, 32'b000001, 32'b000000);
        check("stop pend", {31'd0, bus.pend}, 32'd0);
        bus.en = 1'b1;
        expect_wave("restart", 4, 32'b0111, 32'b0001);

        // Clamp: 0 loaded from N=6 becomes 2
        bus.div_val  = 8'd0;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        check("clamp0 pend", {31'd0, bus.pend}, 32'd1);
        step();
        step();
        check("clamp0 cur_div", 32'(bus.cur_div), 32'd2);
        check("clamp0 pend clr", {31'd0, bus.pend}, 32'd0);

        // Clamp: 1 becomes 2
        bus.div_val  = 8'd1;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        check("clamp1 pend", {31'd0, bus.pend}, 32'd1);
        step();
        check("clamp1 cur_div", 32'(bus.cur_div), 32'd2);
        check("clamp1 pend clr", {31'd0, bus.pend}, 32'd0);

        // Idle load applies on the next edge
        bus.en = 1'b0;
        step();
        step();
        step();
        check("idle2 clk_out", {31'd0, bus.clk_out}, 32'd0);
        bus.div_val  = 8'd9;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        check("idleload pend", {31'd0, bus.pend}, 32'd1);
        check("idleload cur_div a", 32'(bus.cur_div), 32'd2);
        step();
        check("idleload cur_div", 32'(bus.cur_div), 32'd9);
        check("idleload pend clr", {31'd0, bus.pend}, 32'd0);

        // Asynchronous reset while clk_out is high with a load pending
        bus.en       = 1'b1;
        bus.div_val  = 8'd3;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        check("prerst clk_out", {31'd0, bus.clk_out}, 32'd1);
        check("prerst pend", {31'd0, bus.pend}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst clk_out", {31'd0, bus.clk_out}, 32'd0);
        check("arst tick", {31'd0, bus.tick}, 32'd0);
        check("arst pend", {31'd0, bus.pend}, 32'd0);
        check("arst cur_div", 32'(bus.cur_div), 32'd2);
        bus.en = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        check("postrst clk_out", {31'd0, bus.clk_out}, 32'd0);
        check("postrst cur_div", 32'(bus.cur_div), 32'd2);
        check("postrst pend", {31'd0, bus.pend}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
